async_gray_chan_dst: RTL and testbench

ASYNC_GRAY_CHAN_DST -- requirements
Module: async_gray_chan_dst

---
 rtl/async_gray_chan_dst.sv | 79 +++++++
 tb/tb_async_gray_chan_dst.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_gray_chan_dst.sv
// rtl/async_gray_chan_dst.sv - destination half of a Gray-pointer async FIFO channel with 1-entry output register
`timescale 1ns/1ps
module async_gray_chan_dst #(
  parameter int DATA_WIDTH  = 64,
  parameter int LOG_DEPTH   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [LOG_DEPTH:0]                    async_wptr_i,
  input  logic [(2**LOG_DEPTH)*DATA_WIDTH-1:0]  async_data_i,
  output logic [LOG_DEPTH:0]                    async_rptr_o,
  output logic [DATA_WIDTH-1:0]                 dst_data_o,
  output logic                                  dst_valid_o,
  input  logic                                  dst_ready_i
);

  localparam int PW    = LOG_DEPTH + 1;
  localparam int DEPTH = 2 ** LOG_DEPTH;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         wptr_sync;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         rptr_next;
  logic [DATA_WIDTH-1:0] entries [DEPTH];
  logic                  empty;
  logic                  pop;

  // Unpack the flattened source storage so entries can be indexed by read address
  for (genvar k = 0; k < DEPTH; k++) begin : g_entries
    assign entries[k] = async_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Synchronizer chain: the only sampling point of the source-domain write pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_wptr_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wptr_sync = sync_q[SYNC_STAGES-1];
  assign rptr_next = rptr + PW'(1);

  // async_rptr_o always holds gray(rptr), so comparing against it is the empty test
  assign empty = (wptr_sync == async_rptr_o);
  assign pop   = !empty && (!dst_valid_o || dst_ready_i);

  // Read pointer and its Gray image; both advance only on a pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr         <= '0;
      async_rptr_o <= '0;
    end else if (pop) begin
      rptr         <= rptr_next;
      async_rptr_o <= bin2gray(rptr_next);
    end
  end

  // Output register: load on pop, drop valid on a handshake with nothing to refill
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dst_valid_o <= 1'b0;
      dst_data_o  <= '0;
    end else if (pop) begin
      dst_valid_o <= 1'b1;
      dst_data_o  <= entries[rptr[LOG_DEPTH-1:0]];
    end else if (dst_valid_o && dst_ready_i) begin
      dst_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_async_gray_chan_dst.sv
// tb/tb_async_gray_chan_dst.sv - self-checking bench for async_gray_chan_dst
`timescale 1ns/1ps
module tb_async_gray_chan_dst;

  localparam int DW    = 8;
  localparam int LD    = 1;
  localparam int SS    = 2;
  localparam int DEPTH = 2;
  localparam int PW    = 2;
  localparam int LIMIT = 95000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PW-1:0]     wptr_in = '0;
  logic [DEPTH*DW-1:0] data_in = '0;
  logic [PW-1:0]     rptr_out;
  logic [DW-1:0]     data_out;
  logic              valid;
  logic              ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  async_gray_chan_dst #(.DATA_WIDTH(DW), .LOG_DEPTH(LD), .SYNC_STAGES(SS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .async_wptr_i (wptr_in),
    .async_data_i (data_in),
    .async_rptr_o (rptr_out),
    .dst_data_o   (data_out),
    .dst_valid_o  (valid),
    .dst_ready_i  (ready)
  );

  always #5 clk = ~clk;

  logic src_clk = 1'b0;
  int   src_half = 5;
  initial forever begin
    #(src_half) src_clk = ~src_clk;
  end

  // Source-side model: a 2-entry FIFO writer in its own clock domain
  bit            src_en = 0;
  bit            src_rand = 0;
  int            src_limit = 0;
  int            src_sent = 0;
  logic [PW-1:0] src_wb = '0;
  logic [PW-1:0] rs1 = '0, rs2 = '0;
  logic [DW-1:0] exp_q [$];

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    for (int i = 0; i < 4; i++) if (gray_seq[i] == g) return PW'(i);
    return '0;
  endfunction

  initial forever begin
    logic [PW-1:0] used;
    logic [DW-1:0] d;
    int idx;
    @(posedge src_clk);
    if (src_en) begin
      used = src_wb - g2b(rs2);
      if (src_sent < src_limit && used != PW'(DEPTH) &&
          (!src_rand || $urandom_range(0, 3) != 0)) begin
        d = src_rand ? 8'($urandom) : 8'(src_sent + 1);
        idx = int'(src_wb) % DEPTH;
        data_in[idx*DW +: DW] = d;
        exp_q.push_back(d);
        src_sent++;
        src_wb = src_wb + PW'(1);
        wptr_in = gray_seq[int'(src_wb)];
      end
      rs2 = rs1;
      rs1 = rptr_out;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic src_reset();
    src_en = 0;
    src_sent = 0;
    src_wb = '0;
    rs1 = '0;
    rs2 = '0;
    data_in = '0;
    wptr_in = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b0;
    src_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_stream(input int beats, input bit rand_ready, input bit vary_ratio);
    int rx = 0;
    int cyc = 0;
    bit hold = 0;
    logic [DW-1:0] hold_data = '0;
    logic [PW-1:0] hold_rptr = '0;
    logic [PW-1:0] prev = rptr_out;
    while (rx < beats && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      check("rptr_hamming", 64'($countones(prev ^ rptr_out) <= 1), 64'd1);
      prev = rptr_out;
      if (hold) begin
        check("hold_valid", valid, 1);
        check("hold_data", data_out, hold_data);
        check("hold_rptr", rptr_out, hold_rptr);
      end
      if (vary_ratio && cyc % 400 == 0) src_half = $urandom_range(2, 15);
      ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (valid && ready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("sb_data", data_out, exp_q.pop_front());
        check("rptr_seq", rptr_out, gray_seq[(rx + 1) % 4]);
        rx++;
      end
      hold = valid && !ready;
      hold_data = data_out;
      hold_rptr = rptr_out;
    end
    check("stream_done", rx, beats);
  endtask

  initial begin
    int waited;
    src_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data_out, 0);
    check("rst_rptr", rptr_out, 0);
    rst_n = 1'b1;

    // idle after reset
    repeat (20) begin
      @(negedge clk);
      check("idle_valid", valid, 0);
      check("idle_rptr", rptr_out, 0);
    end

    // single beat: latency SYNC_STAGES+1
    do_reset();
    data_in[7:0] = 8'hA5;
    wptr_in = 2'b01;
    ready = 1'b1;
    @(negedge clk);
    check("single_e1_valid", valid, 0);
    @(negedge clk);
    check("single_e2_valid", valid, 0);
    @(negedge clk);
    check("single_e3_valid", valid, 1);
    check("single_e3_data", data_out, 8'hA5);
    check("single_e3_rptr", rptr_out, 2'b01);
    @(negedge clk);
    check("single_e4_valid", valid, 0);
    check("single_e4_data", data_out, 8'hA5);
    check("single_e4_rptr", rptr_out, 2'b01);

    // backpressure with two entries pending
    do_reset();
    data_in = {8'hB6, 8'hA5};
    wptr_in = 2'b11;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    repeat (10) begin
      check("bp_valid", valid, 1);
      check("bp_data", data_out, 8'hA5);
      check("bp_rptr", rptr_out, 2'b01);
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", valid, 1);
    check("bp_rel_data", data_out, 8'hB6);
    check("bp_rel_rptr", rptr_out, 2'b11);
    @(negedge clk);
    check("bp_end_valid", valid, 0);

    // wrap-around streaming 0x01..0x06
    do_reset();
    src_half = 5;
    src_rand = 0;
    src_limit = 6;
    src_en = 1;
    run_stream(6, 0, 0);

    // randomized ready and source clock ratio
    do_reset();
    src_rand = 1;
    src_limit = 10000;
    src_en = 1;
    run_stream(10000, 1, 1);

    // asynchronous reset while a beat is held
    ready = 1'b0;
    src_limit = 10010;
    waited = 0;
    while (!valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("midrst_valid_seen", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_data", data_out, 0);
    check("midrst_rptr", rptr_out, 0);
    src_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
